tone_decoder: RTL and testbench

Qualifies the five band-pass tone-detector comparator lines and turns a stable single tone into a junction command for the drive state machine. It sits directly upstream of the drive controller's JUNCTION handling. It presents `tdEn`/`tdDir` as a held request that stays up until the drive side acknowledges it. A re-arm gap prevents one long tone from issuing repeated commands.

---
 rtl/drive_pkg.sv | 40 ++++
 rtl/tone_sync.sv | 27 ++
 rtl/tone_decoder.sv | 144 ++++++++++++++
 tb/tb_tone_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared drive-side definitions: direction codes, tone FSM states, counter width.
package drive_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'b00,
    DIR_LEFT     = 2'b01,
    DIR_RIGHT    = 2'b10,
    DIR_BACK     = 2'b11
  } dirE;

  typedef enum logic [1:0] {
    TD_IDLE    = 2'b00,
    TD_QUALIFY = 2'b01,
    TD_VALID   = 2'b10,
    TD_RELEASE = 2'b11
  } tdStateE;

  // True when exactly one of the four direction tones is present.
  function automatic logic oneHot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Map a one-hot tone vector (bit 0 = STRAIGHT) to its direction code.
  function automatic dirE toDir(input logic [3:0] v);
    dirE d;
    d = DIR_STRAIGHT;
    if (v[1]) d = DIR_LEFT;
    if (v[2]) d = DIR_RIGHT;
    if (v[3]) d = DIR_BACK;
    return d;
  endfunction

  // Tone vector that corresponds to a captured direction code.
  function automatic logic [3:0] dirMask(input dirE d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/tone_sync.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low clear.
module tone_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] metaReg;
  logic [W-1:0] syncReg;

  // Two back-to-back flops give metastability a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      metaReg <= '0;
      syncReg <= '0;
    end else begin
      metaReg <= d;
      syncReg <= metaReg;
    end
  end

  assign q = syncReg;

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder: qualifies a single stable band-pass tone into a held junction
// command (tdEn/tdDir) that stays up until tdAck, then waits for a silent gap.
// Optional feature macro TONE_STOP_EN: qualifies bp5 into a one-cycle tdStop
// pulse that also cancels any pending command.
module tone_decoder
  import drive_pkg::*;
#(
  parameter int QUAL_CYCLES = 1_000_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  input  logic       tdAck,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic       tdStop
);

  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [4:0]       s;         // s[3:0] = STRAIGHT..BACK, s[4] = STOP
  logic [3:0]       tones;
  tdStateE          stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  dirE              dirReg, dirNext;   // captured tone code
  logic             tdEnReg;
  logic [1:0]       tdDirReg;
  logic             tdStopReg;
  logic             stopFire;

  tone_sync #(.W(5)) uSync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({bp5, bp4, bp3, bp2, bp1}),
    .q     (s)
  );

  assign tones = s[3:0];

`ifdef TONE_STOP_EN
  logic [CNT_W-1:0] stopCntReg;
  logic             stopDoneReg;

  assign stopFire = s[4] && !stopDoneReg && (stopCntReg == QUAL_LAST);

  // Independent stop qualifier; re-arms only once the stop tone has gone away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stopCntReg  <= '0;
      stopDoneReg <= 1'b0;
    end else if (!s[4]) begin
      stopCntReg  <= '0;
      stopDoneReg <= 1'b0;
    end else if (!stopDoneReg) begin
      if (stopFire) begin
        stopCntReg  <= '0;
        stopDoneReg <= 1'b1;
      end else begin
        stopCntReg <= stopCntReg + CNT_ONE;
      end
    end
  end
`else
  logic unusedStopTone;
  assign unusedStopTone = s[4];
  assign stopFire       = 1'b0;
`endif

  // State, shared counter, captured code and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= TD_IDLE;
      cntReg    <= '0;
      dirReg    <= DIR_STRAIGHT;
      tdEnReg   <= 1'b0;
      tdDirReg  <= 2'b00;
      tdStopReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      dirReg    <= dirNext;
      tdEnReg   <= (stateNext == TD_VALID);
      if (stateNext == TD_VALID) tdDirReg <= dirNext;
      tdStopReg <= stopFire;
    end
  end

  // Next-state logic; a qualified stop overrides every state.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    dirNext   = dirReg;
    unique case (stateReg)
      TD_IDLE: begin
        if (oneHot4(tones)) begin
          dirNext   = toDir(tones);
          cntNext   = '0;
          stateNext = TD_QUALIFY;
        end
      end
      TD_QUALIFY: begin
        if (tones != dirMask(dirReg)) begin
          stateNext = TD_IDLE;
        end else if (cntReg == QUAL_LAST) begin
          stateNext = TD_VALID;
        end else begin
          cntNext = cntReg + CNT_ONE;
        end
      end
      TD_VALID: begin
        if (tdAck) begin
          cntNext   = '0;
          stateNext = TD_RELEASE;
        end
      end
      TD_RELEASE: begin
        if (tones != 4'd0) begin
          cntNext = '0;
        end else if (cntReg == GAP_LAST) begin
          stateNext = TD_IDLE;
        end else begin
          cntNext = cntReg + CNT_ONE;
        end
      end
      default: stateNext = TD_IDLE;
    endcase
    if (stopFire) begin
      cntNext   = '0;
      stateNext = TD_RELEASE;
    end
  end

  assign tdEn   = tdEnReg;
  assign tdDir  = tdDirReg;
  assign tdStop = tdStopReg;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with QUAL_CYCLES=8, GAP_CYCLES=4. Expected commands
// are queued when a tone is driven and matched when tdEn rises.
module tb_tone_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bp1, bp2, bp3, bp4, bp5;
  logic       tdAck;
  logic       tdEn;
  logic [1:0] tdDir;
  logic       tdStop;

  tone_decoder #(.QUAL_CYCLES(8), .GAP_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bp1    (bp1),
    .bp2    (bp2),
    .bp3    (bp3),
    .bp4    (bp4),
    .bp5    (bp5),
    .tdAck  (tdAck),
    .tdEn   (tdEn),
    .tdDir  (tdDir),
    .tdStop (tdStop)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] dir;
    int         cyc;
  } expT;
  expT expQ[$];

  int   riseCount = 0;
  int   stopCount = 0;
  logic prevEn = 1'b0;
  expT  monExp;

  // Scoreboard monitor: every rising tdEn must match the oldest queued command.
  always @(negedge clk) begin
    if (tdEn === 1'b1 && prevEn !== 1'b1) begin
      riseCount++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: tdEn rose at cycle %0d tdDir=%b, required no command", cycleCnt, tdDir);
      end else begin
        monExp = expQ.pop_front();
        if (tdDir !== monExp.dir || cycleCnt != monExp.cyc) begin
          errors++;
          $display("FAIL cmd_match: got dir=%b cycle=%0d, required dir=%b cycle=%0d",
                   tdDir, cycleCnt, monExp.dir, monExp.cyc);
        end else begin
          $display("cmd dir=%b at cycle %0d ok", tdDir, cycleCnt);
        end
      end
    end
    if (tdStop === 1'b1) stopCount++;
    prevEn = tdEn;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pushCmd(input logic [1:0] dir, input int cyc);
    expT e;
    e.dir = dir;
    e.cyc = cyc;
    expQ.push_back(e);
  endtask

  task automatic ackAndDrop();
    tdAck = 1'b1;
    tick();
    tdAck = 1'b0;
    bp1 = 0; bp2 = 0; bp3 = 0; bp4 = 0; bp5 = 0;
    ticks(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bp1 = 0; bp2 = 0; bp3 = 0; bp4 = 0; bp5 = 0; tdAck = 0;
    ticks(3);
    checks++;
    if (tdEn !== 1'b0) begin errors++; $display("FAIL reset_tdEn: got %b, required 0", tdEn); end
    checks++;
    if (tdDir !== 2'b00) begin errors++; $display("FAIL reset_tdDir: got %b, required 00", tdDir); end
    checks++;
    if (tdStop !== 1'b0) begin errors++; $display("FAIL reset_tdStop: got %b, required 0", tdStop); end
    rst_n = 1'b1;
    ticks(2);
    $display("reset done at cycle %0d", cycleCnt);
  endtask

  task automatic test_single_tone();
    int n;
    int bad;
    n = cycleCnt;
    bp3 = 1'b1;
    pushCmd(2'b10, n + 11);
    ticks(11);
    checks++;
    if (expQ.size() != 0 || tdEn !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: tdEn=%b pending=%0d, required tdEn=1 pending=0", tdEn, expQ.size());
      expQ.delete();
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tdEn !== 1'b1 || tdDir !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_hold: %0d unstable cycles, required 0", bad); end
    tdAck = 1'b1;
    tick();
    tdAck = 1'b0;
    checks++;
    if (tdEn !== 1'b0) begin errors++; $display("FAIL single_ack: tdEn=%b, required 0", tdEn); end
    bp3 = 1'b0;
    ticks(12);
    $display("single tone transaction done");
  endtask

  task automatic test_short_tone();
    int r;
    int n;
    r = riseCount;
    bp2 = 1'b1;
    ticks(6);
    bp2 = 1'b0;
    ticks(20);
    checks++;
    if (riseCount != r || tdEn !== 1'b0) begin
      errors++;
      $display("FAIL short_tone: rises=%0d tdEn=%b, required rises=%0d tdEn=0", riseCount - r, tdEn, 0);
    end
    // A full-latency command right afterwards shows the FSM is back in IDLE.
    n = cycleCnt;
    bp1 = 1'b1;
    pushCmd(2'b00, n + 11);
    ticks(11);
    checks++;
    if (expQ.size() != 0 || tdEn !== 1'b1) begin
      errors++;
      $display("FAIL short_then_idle: tdEn=%b pending=%0d, required tdEn=1 pending=0", tdEn, expQ.size());
      expQ.delete();
    end
    ackAndDrop();
    $display("short tone transaction done");
  endtask

  task automatic test_two_tones();
    int r;
    r = riseCount;
    bp1 = 1'b1;
    bp4 = 1'b1;
    ticks(20);
    bp1 = 1'b0;
    bp4 = 1'b0;
    ticks(6);
    checks++;
    if (riseCount != r || tdEn !== 1'b0) begin
      errors++;
      $display("FAIL two_tones: rises=%0d tdEn=%b, required rises=0 tdEn=0", riseCount - r, tdEn);
    end
    $display("two tones transaction done");
  endtask

  task automatic test_ack_rearm();
    int n;
    int r;
    n = cycleCnt;
    bp4 = 1'b1;
    pushCmd(2'b11, n + 11);
    ticks(15);
    tdAck = 1'b1;
    tick();
    tdAck = 1'b0;
    checks++;
    if (tdEn !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("FAIL rearm_ack: tdEn=%b pending=%0d, required tdEn=0 pending=0", tdEn, expQ.size());
      expQ.delete();
    end
    r = riseCount;
    ticks(24);
    checks++;
    if (riseCount != r || tdEn !== 1'b0) begin
      errors++;
      $display("FAIL rearm_held: rises=%0d tdEn=%b, required rises=0 tdEn=0", riseCount - r, tdEn);
    end
    bp4 = 1'b0;
    ticks(10);
    bp4 = 1'b1;
    pushCmd(2'b11, n + 61);
    ticks(11);
    checks++;
    if (expQ.size() != 0 || tdEn !== 1'b1 || tdDir !== 2'b11) begin
      errors++;
      $display("FAIL rearm_second: tdEn=%b tdDir=%b pending=%0d, required tdEn=1 tdDir=11 pending=0",
               tdEn, tdDir, expQ.size());
      expQ.delete();
    end
    ackAndDrop();
    $display("ack/re-arm transaction done");
  endtask

  task automatic test_async_reset();
    int n;
    n = cycleCnt;
    bp2 = 1'b1;
    pushCmd(2'b01, n + 11);
    ticks(11);
    checks++;
    if (tdEn !== 1'b1 || tdDir !== 2'b01) begin
      errors++;
      $display("FAIL areset_setup: tdEn=%b tdDir=%b, required tdEn=1 tdDir=01", tdEn, tdDir);
      expQ.delete();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tdEn !== 1'b0 || tdDir !== 2'b00 || tdStop !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: tdEn=%b tdDir=%b tdStop=%b, required 0 00 0", tdEn, tdDir, tdStop);
    end
    bp2 = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(3);
    $display("async reset transaction done");
  endtask

  task automatic test_stop();
    int   n;
    int   s0;
    int   found;
    logic enAtStop;
    logic enBefore;
    logic enLast;
    n = cycleCnt;
    bp1 = 1'b1;
    pushCmd(2'b00, n + 11);
    ticks(11);
    checks++;
    if (tdEn !== 1'b1 || expQ.size() != 0) begin
      errors++;
      $display("FAIL stop_setup: tdEn=%b pending=%0d, required tdEn=1 pending=0", tdEn, expQ.size());
      expQ.delete();
    end
    s0 = stopCount;
    found = 0;
    enAtStop = 1'b1;
    enBefore = 1'b0;
    enLast = tdEn;
    bp1 = 1'b0;
    bp5 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) bp5 = 1'b0;
      tick();
      if (tdStop === 1'b1 && found == 0) begin
        found = 1;
        enAtStop = tdEn;
        enBefore = enLast;
      end
      enLast = tdEn;
    end
`ifdef TONE_STOP_EN
    checks++;
    if (stopCount - s0 != 1) begin
      errors++;
      $display("FAIL stop_pulse: %0d tdStop cycles, required 1", stopCount - s0);
    end
    checks++;
    if (enAtStop !== 1'b0 || enBefore !== 1'b1) begin
      errors++;
      $display("FAIL stop_cancel: tdEn before/at stop=%b/%b, required 1/0", enBefore, enAtStop);
    end
    checks++;
    if (tdEn !== 1'b0) begin errors++; $display("FAIL stop_after: tdEn=%b, required 0", tdEn); end
`else
    checks++;
    if (stopCount != s0) begin
      errors++;
      $display("FAIL stop_disabled: %0d tdStop cycles, required 0", stopCount - s0);
    end
    checks++;
    if (tdEn !== 1'b1) begin errors++; $display("FAIL stop_disabled_hold: tdEn=%b, required 1", tdEn); end
`endif
    ackAndDrop();
    $display("stop transaction done");
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_short_tone();
    test_two_tones();
    test_ack_rearm();
    test_async_reset();
    test_stop();
    ticks(5);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d commands never seen, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
